// File: rtl/riscv_pkg.sv
// Shared execute/memory definitions: flag bit positions, branch funct3 codes,
// FIFO occupancy states and the buffered entry layout.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_e;

  // Everything an entry carries besides its result word.
  typedef struct packed {
    logic [4:0] rd;
    logic       wr_en;
    logic [3:0] flags;
  } ex_meta_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [4:0]      rd;
    logic            wr_en;
    logic [3:0]      flags;
  } ex_entry_t;

endpackage

// File: rtl/branch_cond.sv
// Branch decision from compare-subtract flags; C = 1 means no borrow.
module branch_cond
  import riscv_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [2:0] br_op,
  output logic       taken
);

  logic n_f, z_f, c_f, v_f;

  assign n_f = flags[FLAG_N];
  assign z_f = flags[FLAG_Z];
  assign c_f = flags[FLAG_C];
  assign v_f = flags[FLAG_V];

  always_comb begin
    taken = 1'b0;
    case (br_op)
      F3_BEQ:  taken = z_f;
      F3_BNE:  taken = !z_f;
      F3_BLT:  taken = n_f ^ v_f;
      F3_BGE:  taken = !(n_f ^ v_f);
      F3_BLTU: taken = !c_f;
      F3_BGEU: taken = c_f;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM boundary: 2-deep in-order skid FIFO with branch redirect generation
// and a saturating taken-branch counter.
module ex_mem_stage
  import riscv_pkg::*;
#(
  parameter int A_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] alu_result,
  input  logic [3:0]         alu_flags,
  input  logic [4:0]         rd,
  input  logic               wr_en,
  input  logic               is_branch,
  input  logic [2:0]         br_op,
  input  logic [A_WIDTH-1:0] br_target,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_WIDTH-1:0] out_result,
  output logic [4:0]         out_rd,
  output logic               out_wr_en,
  output logic [3:0]         out_flags,
  output logic               redirect_valid,
  output logic [A_WIDTH-1:0] redirect_pc,
  output logic [15:0]        taken_cnt
);

  occ_state_e         state_q, state_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic [A_WIDTH-1:0] res_q [2];
  logic [A_WIDTH-1:0] res_d [2];
  ex_meta_t           meta_q [2];
  ex_meta_t           meta_d [2];
  logic               redirect_valid_q, redirect_valid_d;
  logic [A_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic [15:0]        taken_cnt_q, taken_cnt_d;

  logic push, pop, br_taken, taken_push;

  branch_cond u_branch_cond (
    .flags (alu_flags),
    .br_op (br_op),
    .taken (br_taken)
  );

  // Handshake sides depend only on registered occupancy.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);

  assign push       = in_valid && in_ready && !flush;
  assign pop        = out_valid && out_ready && !flush;
  assign taken_push = push && is_branch && br_taken;

  always_comb begin
    state_d          = state_q;
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    res_d            = res_q;
    meta_d           = meta_q;
    redirect_valid_d = taken_push;
    redirect_pc_d    = taken_push ? br_target : redirect_pc_q;
    taken_cnt_d      = (taken_push && (taken_cnt_q != 16'hFFFF)) ? taken_cnt_q + 16'd1
                                                                  : taken_cnt_q;
    if (flush) begin
      state_d  = ST_EMPTY;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) begin
        res_d[wr_ptr_q]        = alu_result;
        meta_d[wr_ptr_q].rd    = rd;
        meta_d[wr_ptr_q].wr_en = wr_en && (rd != 5'd0) && !is_branch;
        meta_d[wr_ptr_q].flags = alu_flags;
        wr_ptr_d               = !wr_ptr_q;
      end
      if (pop) rd_ptr_d = !rd_ptr_q;
      case (state_q)
        ST_EMPTY: if (push) state_d = ST_ONE;
        ST_ONE:   if (push && !pop) state_d = ST_FULL;
                  else if (pop && !push) state_d = ST_EMPTY;
        ST_FULL:  if (pop) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_EMPTY;
      rd_ptr_q         <= 1'b0;
      wr_ptr_q         <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        res_q[i]  <= '0;
        meta_q[i] <= '0;
      end
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      taken_cnt_q      <= '0;
    end else begin
      state_q          <= state_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      for (int i = 0; i < 2; i++) begin
        res_q[i]  <= res_d[i];
        meta_q[i] <= meta_d[i];
      end
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      taken_cnt_q      <= taken_cnt_d;
    end
  end

  assign out_result     = res_q[rd_ptr_q];
  assign out_rd         = meta_q[rd_ptr_q].rd;
  assign out_wr_en      = meta_q[rd_ptr_q].wr_en;
  assign out_flags      = meta_q[rd_ptr_q].flags;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign taken_cnt      = taken_cnt_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed plus random bench for ex_mem_stage against a queue-based model.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_result = '0;
  logic [3:0]  alu_flags = '0;
  logic [4:0]  rd = '0;
  logic        wr_en = 1'b0;
  logic        is_branch = 1'b0;
  logic [2:0]  br_op = '0;
  logic [31:0] br_target = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wr_en;
  logic [3:0]  out_flags;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [15:0] taken_cnt;

  ex_mem_stage #(.A_WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .alu_result     (alu_result),
    .alu_flags      (alu_flags),
    .rd             (rd),
    .wr_en          (wr_en),
    .is_branch      (is_branch),
    .br_op          (br_op),
    .br_target      (br_target),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_rd         (out_rd),
    .out_wr_en      (out_wr_en),
    .out_flags      (out_flags),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .taken_cnt      (taken_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        wr_en;
    logic [3:0]  flags;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] cnt_m = '0;
  logic        red_m = 1'b0;
  logic [31:0] pc_m = '0;

  function automatic logic taken_m(input logic [2:0] op, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (op)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return n != v;
      3'd5:    return n == v;
      3'd6:    return !c;
      3'd7:    return c;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] r,
                       input logic we, input logic isb, input logic [2:0] op,
                       input logic [3:0] fl, input logic [31:0] tgt);
    in_valid = v; alu_result = res; rd = r; wr_en = we;
    is_branch = isb; br_op = op; alu_flags = fl; br_target = tgt;
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    if (q.size() > 0) begin
      chk("out_result", out_result, q[0].result);
      chk("out_rd", out_rd, q[0].rd);
      chk("out_wr_en", out_wr_en, q[0].wr_en);
      chk("out_flags", out_flags, q[0].flags);
    end
    chk("redirect_valid", redirect_valid, red_m);
    if (red_m) chk("redirect_pc", redirect_pc, pc_m);
    chk("taken_cnt", taken_cnt, cnt_m);
  endtask

  // One clock of the reference model with the currently driven inputs.
  task automatic step(input bit do_chk);
    bit   acc, pop, tk, fl;
    exp_t e;
    fl  = flush;
    acc = in_valid && (q.size() < 2) && !fl;
    pop = (q.size() > 0) && out_ready && !fl;
    tk  = acc && is_branch && taken_m(br_op, alu_flags);
    e.result = alu_result;
    e.rd     = rd;
    e.wr_en  = wr_en && (rd != 5'd0) && !is_branch;
    e.flags  = alu_flags;
    if (do_chk) chk("in_ready_pre", in_ready, q.size() < 2);
    if (do_chk && pop)
      $display("t=%0t pop  result=%h rd=%0d we=%0b", $time, q[0].result, q[0].rd, q[0].wr_en);
    if (do_chk && acc)
      $display("t=%0t push result=%h rd=%0d br=%0b taken=%0b", $time, e.result, e.rd, is_branch, tk);
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (pop) q.delete(0);
      if (acc) q.push_back(e);
    end
    red_m = tk;
    if (tk) pc_m = br_target;
    if (tk && cnt_m != 16'hFFFF) cnt_m++;
    if (do_chk) check_outputs();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #10;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_out_wr_en", out_wr_en, 1'b0);
    chk("rst_redirect", redirect_valid, 1'b0);
    chk("rst_taken_cnt", taken_cnt, 16'h0);
    @(negedge clk) rst_n = 1'b1;

    // single pass
    out_ready = 1'b1;
    drive(1, 32'h0000_00A5, 5'd5, 1, 0, 3'd0, 4'h0, 32'h0);
    step(1);
    chk("single_result", out_result, 32'hA5);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(1);

    // x0 write suppression
    drive(1, 32'h77, 5'd0, 1, 0, 3'd0, 4'h3, 32'h0);
    step(1);
    chk("x0_wr_en", out_wr_en, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(1);

    // taken BLT, then not-taken BGEU
    drive(1, 32'h1, 5'd3, 1, 1, 3'b100, 4'b1000, 32'h0000_1000);
    step(1);
    chk("blt_redirect", redirect_valid, 1'b1);
    chk("blt_cnt", taken_cnt, 16'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(1);
    drive(1, 32'h2, 5'd4, 1, 1, 3'b111, 4'b0000, 32'h0000_2000);
    step(1);
    chk("bgeu_no_redirect", redirect_valid, 1'b0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(1);

    // backpressure: third entry waits for the first pop
    out_ready = 1'b0;
    drive(1, 32'h1, 5'd1, 1, 0, 0, 4'h1, 0); step(1);
    drive(1, 32'h2, 5'd2, 1, 0, 0, 4'h2, 0); step(1);
    chk("bp_full", in_ready, 1'b0);
    drive(1, 32'h3, 5'd3, 1, 0, 0, 4'h3, 0); step(1);
    step(1);
    out_ready = 1'b1;
    step(1);
    step(1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(1);
    step(1);

    // flush while full with a taken branch presented
    out_ready = 1'b0;
    drive(1, 32'h11, 5'd7, 1, 0, 0, 0, 0); step(1);
    drive(1, 32'h12, 5'd8, 1, 0, 0, 0, 0); step(1);
    drive(1, 32'h13, 5'd9, 0, 1, 3'b000, 4'b0100, 32'h3000);
    flush = 1'b1;
    step(1);
    chk("flush_empty", out_valid, 1'b0);
    chk("flush_no_redirect", redirect_valid, 1'b0);
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 31)),
            1'($urandom), $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
            4'($urandom_range(0, 15)), $urandom);
      out_ready = $urandom_range(0, 2) != 0;
      flush     = $urandom_range(0, 15) == 0;
      step(1);
    end
    flush = 1'b0;

    // saturation: stream taken BEQs until the counter is pinned
    out_ready = 1'b1;
    drive(1, 32'h5, 5'd6, 1, 1, 3'b000, 4'b0100, 32'h4000);
    for (int i = 0; i < 70000 && cnt_m != 16'hFFFF; i++) step(0);
    check_outputs();
    step(1);
    step(1);
    chk("sat_cnt", taken_cnt, 16'hFFFF);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(1);

    // reset mid-operation with two entries held
    out_ready = 1'b0;
    drive(1, 32'h21, 5'd10, 1, 0, 0, 0, 0); step(1);
    drive(1, 32'h22, 5'd11, 1, 0, 0, 0, 0); step(1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b0;
    #1;
    q.delete(); cnt_m = '0; red_m = 1'b0; pc_m = '0;
    chk("rst_mid_out_valid", out_valid, 1'b0);
    chk("rst_mid_taken_cnt", taken_cnt, 16'h0);
    chk("rst_mid_out_result", out_result, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    step(1);
    step(1);
    step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
